// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv
//   EX-stage ALU with valid/ready handshakes and registered results.
//   Single-cycle ops (ADD/SUB/AND/OR/XOR/SLT/SLTU, undefined codes) return
//   on the accepting edge. Mul/div-class ops (MUL/MULH/MULHU/DIV/DIVU/REM/
//   REMU) run a WIDTH-step shift-add multiplier or restoring divider on
//   operand magnitudes, then spend one more cycle applying sign correction.
//
//   Handshake: a request is taken on a rising edge where in_valid && in_ready.
//   A result is handed over on a rising edge where out_valid && out_ready.
//   in_ready is high only in IDLE; out_valid is high only in DONE, where res
//   and eq are held until the consumer takes them.
//
//   Optional build macro ALU_EARLY_OUT_EN: mul/div ops whose result is known
//   up front (b==0, or a==0 for multiplies) skip the iteration engine.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  request handshake; op, a, b are the request payload
//   out_valid/ready result handshake; res, eq, res_msb are the payload
//   dbg_state_o     current FSM state (IDLE=0, ITER=1, DONE=2)
module alu_seq_muldiv #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             eq,
  output logic             res_msb,
  output logic [1:0]       dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SLTU  = 4'h6;
  localparam logic [3:0] OP_MUL   = 4'h8;
  localparam logic [3:0] OP_MULH  = 4'h9;
  localparam logic [3:0] OP_MULHU = 4'hA;
  localparam logic [3:0] OP_DIV   = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_REM   = 4'hD;
  localparam logic [3:0] OP_REMU  = 4'hE;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  function automatic logic is_mul_op(input logic [3:0] o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHU);
  endfunction

  // Single-cycle datapath; undefined codes (0111, 1111) fall to zero.
  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] o,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    case (o)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // State and datapath registers
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;         // raw dividend, returned by REM/REMU on /0
  logic [WIDTH-1:0] mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier bits / quotient shift reg
  logic             neg_q, neg_d;     // product or quotient must be negated
  logic             rneg_q, rneg_d;   // remainder must be negated
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             eq_q, eq_d;

  // Request decode
  logic             in_is_md, in_is_mul, in_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             early_hit;
  logic [WIDTH-1:0] early_res;

  assign in_is_mul = is_mul_op(op);
  assign in_is_md  = op[3] && (op != 4'hF);
  assign in_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg     = in_signed && a[WIDTH-1];
  assign b_neg     = in_signed && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

`ifdef ALU_EARLY_OUT_EN
  assign early_hit = in_is_md && ((b == '0) || (in_is_mul && (a == '0)));
`else
  assign early_hit = 1'b0;
`endif

  // Only reachable for a zero operand: products are 0, quotients all-ones,
  // remainders equal the dividend.
  always_comb begin
    early_res = '0;
    if (!in_is_mul) begin
      if ((op == OP_DIV) || (op == OP_DIVU)) early_res = '1;
      else                                   early_res = a;
    end
  end

  // One engine step
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [WIDTH-1:0] hi_n, lo_n;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand_q};
    if (is_mul_op(op_q)) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      hi_n = div_trial[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = div_shift[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and result selection once all WIDTH steps are done
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, final_res;

  always_comb begin
    prod_s    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s     = neg_q ? -lo_q : lo_q;
    rem_s     = rneg_q ? -hi_q : hi_q;
    final_res = '0;
    case (op_q)
      OP_MUL:   final_res = lo_q;
      OP_MULH:  final_res = prod_s[2*WIDTH-1:WIDTH];
      OP_MULHU: final_res = hi_q;
      OP_DIV:   final_res = bzero_q ? '1 : quo_s;
      OP_DIVU:  final_res = bzero_q ? '1 : lo_q;
      OP_REM:   final_res = bzero_q ? a_q : rem_s;
      OP_REMU:  final_res = bzero_q ? a_q : hi_q;
      default:  final_res = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    res_d   = res_q;
    eq_d    = eq_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = a;
          eq_d    = (a == b);
          bzero_d = (b == '0);
          if (!in_is_md) begin
            res_d   = alu_single(op, a, b);
            state_d = S_DONE;
          end else if (early_hit) begin
            res_d   = early_res;
            state_d = S_DONE;
          end else begin
            state_d = S_ITER;
            cnt_d   = '0;
            hi_d    = '0;
            mcand_d = in_is_mul ? a_mag : b_mag;
            lo_d    = in_is_mul ? b_mag : a_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end
        end
      end
      S_ITER: begin
        // WIDTH engine steps, then one extra cycle for sign correction.
        if (cnt_q != LAST_CNT) begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          res_d   = final_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      res_q   <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign res         = res_q;
  assign eq          = eq_q;
  assign res_msb     = res_q[WIDTH-1];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
module tb_alu_seq_muldiv;

  localparam int W  = 32;
  localparam int LI = W + 1;  // rising edges from accept edge to out_valid, iterative ops
`ifdef ALU_EARLY_OUT_EN
  localparam int LZ = 0;      // mul/div with a zero operand
`else
  localparam int LZ = W + 1;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;
  logic         eq;
  logic         res_msb;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  alu_seq_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .eq(eq), .res_msb(res_msb),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         eq;
    int           lat;  // rising edges after the accepting edge until out_valid
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [3:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] r, input logic e,
                     input int l);
    vec_t v;
    v.name = n; v.op = o; v.a = x; v.b = y; v.res = r; v.eq = e; v.lat = l;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Presents one request with out_ready held high and checks the whole
  // transaction: acceptance, latency, payload, and return to IDLE.
  task automatic run_vec(input vec_t v);
    int cyc;
    logic [W-1:0] exp;
    @(negedge clk);
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b; out_ready = 1'b1;
    exp_q.push_back(v.res);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({v.name, ".accepted_in_ready"}, W'(in_ready), W'(0));
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({v.name, ".latency"}, W'(cyc), W'(v.lat));
    exp = exp_q.pop_front();
    check({v.name, ".res"}, res, exp);
    check({v.name, ".res_msb"}, W'(res_msb), W'(exp[W-1]));
    check({v.name, ".eq"}, W'(eq), W'(v.eq));
    @(posedge clk); #1;
    check({v.name, ".out_valid_drop"}, W'(out_valid), W'(0));
    check({v.name, ".in_ready_back"}, W'(in_ready), W'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    add("add_ovf",   4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 0);
    add("slt",       4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 0);
    add("sltu",      4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 0);
    add("sub_eq",    4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 0);
    add("and",       4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 0);
    add("or",        4'h3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 0);
    add("xor",       4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 0);
    add("undef7",    4'h7, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 0);
    add("undefF",    4'hF, 32'h12345678, 32'h00000009, 32'h00000000, 1'b0, 0);
    add("mulh_neg",  4'h9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, LI);
    add("mul_neg",   4'h8, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b0, LI);
    add("mulhu_max", 4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, LI);
    add("mul_max",   4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, LI);
    add("mul_small", 4'h8, 32'h00012345, 32'h00000100, 32'h01234500, 1'b0, LI);
    add("mulh_min",  4'h9, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1, LI);
    add("mulh_nn",   4'h9, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000000, 1'b1, LI);
    add("mulh_a0",   4'h9, 32'h00000000, 32'h00000005, 32'h00000000, 1'b0, LZ);
    add("div_m7",    4'hB, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, LI);
    add("rem_m7",    4'hD, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, LI);
    add("div_ovf",   4'hB, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, LI);
    add("rem_ovf",   4'hD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, LI);
    add("div_negb",  4'hB, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, LI);
    add("rem_negb",  4'hD, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, LI);
    add("divu",      4'hC, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, LI);
    add("remu",      4'hE, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, LI);
    add("divu_same", 4'hC, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000001, 1'b1, LI);
    add("divu_z",    4'hC, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b0, LZ);
    add("remu_z",    4'hE, 32'h00001234, 32'h00000000, 32'h00001234, 1'b0, LZ);
    add("div_negz",  4'hB, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 1'b0, LZ);
    add("rem_negz",  4'hD, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1'b0, LZ);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready",  W'(in_ready),  W'(1));
    check("rst.out_valid", W'(out_valid), W'(0));
    check("rst.res",       res,           W'(0));
    check("rst.eq",        W'(eq),        W'(0));
    check("rst.res_msb",   W'(res_msb),   W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held while out_ready is low; a waiting request
    // is only taken after the result is consumed.
    @(negedge clk);
    in_valid = 1'b1; op = 4'h0; a = 32'd10; b = 32'd20; out_ready = 1'b0;
    @(posedge clk); #1;
    op = 4'h1; a = 32'd9; b = 32'd9;  // next request, held by requester
    for (int i = 0; i < 10; i++) begin
      check("bp.out_valid", W'(out_valid), W'(1));
      check("bp.res",       res,           32'd30);
      check("bp.eq",        W'(eq),        W'(0));
      check("bp.in_ready",  W'(in_ready),  W'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.release_out_valid", W'(out_valid), W'(0));
    check("bp.release_in_ready",  W'(in_ready),  W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.next_out_valid", W'(out_valid), W'(1));
    check("bp.next_res",       res,           32'd0);
    check("bp.next_eq",        W'(eq),        W'(1));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.next_done", W'(in_ready), W'(1));

    // Reset in the middle of an iterative DIVU
    @(negedge clk);
    in_valid = 1'b1; op = 4'hC; a = 32'd9; b = 32'd9; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check("midrst.busy_in_ready", W'(in_ready), W'(0));
    check("midrst.busy_eq",       W'(eq),       W'(1));
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", W'(out_valid), W'(0));
    check("midrst.res",       res,           W'(0));
    check("midrst.eq",        W'(eq),        W'(0));
    check("midrst.in_ready",  W'(in_ready),  W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      v.name = "post_rst_add"; v.op = 4'h0; v.a = 32'd2; v.b = 32'd3;
      v.res = 32'd5; v.eq = 1'b0; v.lat = 0;
      run_vec(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
